// File: rtl/demux_dispatch_pkg.sv
// Shared types and helpers for the demux dispatch front end and recurse_demux benches.
package demux_dispatch_pkg;

  localparam int S_DEFAULT = 2;
  localparam int N_DEFAULT = 2 ** S_DEFAULT;

  // Widest lane select the onehot helper supports.
  localparam int MAX_S = 8;
  localparam int MAX_N = 1 << MAX_S;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // One-hot decode of sel; out-of-range selects for an s-bit lane space give zero.
  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_S-1:0] sel, input int s);
    logic [MAX_N-1:0] r;
    r = '0;
    if (int'(sel) < (1 << s)) begin
      r[sel] = 1'b1;
    end else begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_dispatch_rr_counter.sv
// W-bit wrapping counter with enable and synchronous reset; shared with the mux-side arbiter.
module rr_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count register: wraps naturally at 2**W.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/demux_dispatch.sv
// One-entry dispatch register feeding recurse_demux with per-lane valid/ready handshakes.
module demux_dispatch
  import demux_dispatch_pkg::*;
#(
  parameter int S = 2,
  parameter int T = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [T-1:0]        in_data,
  input  logic [S-1:0]        in_dest,
  input  logic                rr_mode,
  output logic [T-1:0]        data,
  output logic [S-1:0]        ctrl,
  output logic [(2**S)-1:0]   lane_valid,
  input  logic [(2**S)-1:0]   lane_ready,
  output logic [S-1:0]        rr_ptr
);

  localparam int N = 2 ** S;

  state_t         state_r;
  state_t         state_s;
  logic [T-1:0]   data_s;
  logic [S-1:0]   ctrl_s;
  logic [N-1:0]   lane_valid_s;
  logic           accept_s;
  logic           handoff_s;
  logic           rr_en_s;

  // Ready passes straight through from the addressed lane once a word is held.
  always_comb begin
    in_ready  = !rst && ((state_r == EMPTY) || lane_ready[ctrl]);
    accept_s  = in_valid && in_ready;
    handoff_s = !rst && (state_r == FULL) && lane_ready[ctrl];
    rr_en_s   = accept_s && rr_mode;
  end

  rr_counter #(
    .W (S)
  ) u_rr_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (rr_en_s),
    .count (rr_ptr)
  );

  // Next-state, next word and next lane-valid decode.
  always_comb begin
    state_s      = state_r;
    data_s       = data;
    ctrl_s       = ctrl;
    lane_valid_s = '0;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          data_s  = in_data;
          ctrl_s  = rr_mode ? rr_ptr : in_dest;
          state_s = FULL;
        end else begin
          state_s = EMPTY;
        end
      end
      FULL: begin
        // A handoff frees the slot in the same cycle, so a concurrent accept refills it.
        if (accept_s) begin
          data_s  = in_data;
          ctrl_s  = rr_mode ? rr_ptr : in_dest;
          state_s = FULL;
        end else if (handoff_s) begin
          state_s = EMPTY;
        end else begin
          state_s = FULL;
        end
      end
      default: begin
        state_s = EMPTY;
      end
    endcase
    if (state_s == FULL) begin
      lane_valid_s = N'(onehot(MAX_S'(ctrl_s), S));
    end else begin
      lane_valid_s = '0;
    end
  end

  // State, held word and registered lane valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= EMPTY;
      data       <= '0;
      ctrl       <= '0;
      lane_valid <= '0;
    end else begin
      state_r    <= state_s;
      data       <= data_s;
      ctrl       <= ctrl_s;
      lane_valid <= lane_valid_s;
    end
  end

endmodule

// File: tb/tb_demux_dispatch.sv
// Directed bench for demux_dispatch with hand-computed expectations.
module tb_demux_dispatch;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic       rr_mode;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic [3:0] lane_valid;
  logic [3:0] lane_ready;
  logic [1:0] rr_ptr;

  int checks = 0;
  int errors = 0;

  demux_dispatch #(.S(2), .T(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .rr_mode    (rr_mode),
    .data       (data),
    .ctrl       (ctrl),
    .lane_valid (lane_valid),
    .lane_ready (lane_ready),
    .rr_ptr     (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] lv, input logic [7:0] d,
                         input logic [1:0] c, input logic [1:0] rp);
    chk({tag, "_lane_valid"}, 32'(lane_valid), 32'(lv));
    chk({tag, "_data"}, 32'(data), 32'(d));
    chk({tag, "_ctrl"}, 32'(ctrl), 32'(c));
    chk({tag, "_rr_ptr"}, 32'(rr_ptr), 32'(rp));
  endtask

  initial begin
    logic [1:0] rr_exp [5];
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst        = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h99;
    in_dest    = 2'd3;
    rr_mode    = 1'b1;
    lane_ready = 4'hF;

    // Reset held two cycles with a word offered.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk_out("rst", 4'b0000, 8'h00, 2'd0, 2'd0);
    end

    // Explicit routing, first accept right after release.
    rst      = 1'b0;
    rr_mode  = 1'b0;
    in_data  = 8'h55;
    in_dest  = 2'd2;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("exp0", 4'b0100, 8'h55, 2'd2, 2'd0);
    in_data = 8'hAA;
    in_dest = 2'd1;
    #1;
    chk("exp1_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("exp1", 4'b0010, 8'hAA, 2'd1, 2'd0);

    // Round-robin, five back-to-back words.
    rr_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(i + 1);
      in_dest = 2'd3;
      #1;
      chk("rr_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("rr_ctrl", 32'(ctrl), 32'(rr_exp[i]));
      chk("rr_data", 32'(data), 32'(i + 1));
      chk("rr_lane_valid", 32'(lane_valid), 32'(4'b0001 << rr_exp[i]));
    end
    chk("rr_ptr_end", 32'(rr_ptr), 32'd1);

    // Handoff with nothing offered: only lane_valid drops.
    in_valid = 1'b0;
    tick();
    chk_out("drain", 4'b0000, 8'h05, 2'd0, 2'd1);

    // Backpressure on lane 3; other lanes ready but ignored.
    in_valid   = 1'b1;
    rr_mode    = 1'b0;
    in_data    = 8'h3C;
    in_dest    = 2'd3;
    lane_ready = 4'b0111;
    tick();
    chk_out("bp_load", 4'b1000, 8'h3C, 2'd3, 2'd1);
    in_data = 8'h77;
    in_dest = 2'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk_out("bp_hold", 4'b1000, 8'h3C, 2'd3, 2'd1);
    end
    lane_ready = 4'hF;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("bp_reload", 4'b0001, 8'h77, 2'd0, 2'd1);

    // Simultaneous handoff and accept on lane 0: no bubble.
    in_data = 8'hE1;
    in_dest = 2'd0;
    #1;
    chk("sim_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("sim0", 4'b0001, 8'hE1, 2'd0, 2'd1);
    in_data = 8'h5A;
    in_dest = 2'd2;
    tick();
    chk_out("sim1", 4'b0100, 8'h5A, 2'd2, 2'd1);

    // Mid-operation reset while FULL on lane 2 with no ready.
    in_valid   = 1'b0;
    lane_ready = 4'h0;
    tick();
    chk_out("mid_hold", 4'b0100, 8'h5A, 2'd2, 2'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk_out("mid_rst", 4'b0000, 8'h00, 2'd0, 2'd0);
    rst        = 1'b0;
    lane_ready = 4'hF;
    tick();
    chk_out("mid_after", 4'b0000, 8'h00, 2'd0, 2'd0);
    tick();
    chk("mid_never", 32'(lane_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_dispatch.md
# demux_dispatch

Upstream feeder for `recurse_demux`: accepts a stream of T-bit words over a valid/ready handshake, selects a destination lane (explicit or round-robin), and holds `data`/`ctrl` stable in a one-entry output register until the addressed lane accepts. Outputs connect directly to the demux `in`/`ctrl` inputs. Per-lane valid/ready wrap the demux's 2**S lanes.

## Interface
- `S`, default 2: select width; lane count N = 2**S.
- `T`, default 8: data word width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: upstream word present.
- `in_ready` out 1: block accepts this cycle.
- `in_data` in T: word to dispatch.
- `in_dest` in S: explicit destination lane (used when `rr_mode`=0).
- `rr_mode` in 1: 1 = round-robin destination, 0 = `in_dest`; sampled on accept.
- `data` out T: registered word, drives demux `in`.
- `ctrl` out S: registered lane select, drives demux `ctrl`.
- `lane_valid` out N: one-hot valid for lane `ctrl`, all zero when empty.
- `lane_ready` in N: per-lane consumer ready.
- `rr_ptr` out S: next round-robin lane.

## Operation
- FSM states: EMPTY, FULL. Reset → EMPTY.
- Reset values: `data`=0, `ctrl`=0, `rr_ptr`=0, `lane_valid`=0, state EMPTY; `in_ready`=0 while `rst`=1.
- `in_ready` = !rst && (EMPTY || `lane_ready[ctrl]`), combinational pass-through ready.
- Accept = `in_valid` && `in_ready`.
- Handoff = FULL && `lane_ready[ctrl]`.
- On accept:
  - `data` ← `in_data`.
  - `ctrl` ← (`rr_mode` ? `rr_ptr` : `in_dest`).
  - Next state FULL.
  - If `rr_mode`=1, `rr_ptr` ← `rr_ptr`+1 mod N. It wraps N−1 → 0.
  - If `rr_mode`=0, `rr_ptr` is unchanged.
- Handoff without accept: state → EMPTY. `data`/`ctrl` retain their last values; only `lane_valid` drops.
- Simultaneous handoff and accept: the new word loads and state stays FULL. No bubble.
- While FULL without handoff, `data` and `ctrl` are frozen bit-exact. Ready on other lanes is ignored.
- `lane_valid` = FULL ? (1 << `ctrl`) : 0. It never has more than one bit set.
- `in_dest` and `in_data` are don't-care when no accept occurs.
- Reset mid-operation: the held word is discarded, the FSM returns to EMPTY, and `rr_ptr` goes to 0. No handoff is signalled in the reset cycle.

## Timing
- Latency: accept at edge k → `lane_valid` asserted after edge k, i.e. during cycle k+1.
- Throughput: 1 word/cycle while the addressed lane holds ready.
- `in_ready` depends combinationally on `lane_ready`. There is no combinational path from `in_valid` to any output.
- All state updates on the rising `clk` edge.

## Structure
- Shared package: `onehot(sel, S)` function and localparam N = 2**S. These are shared with `recurse_demux` benches.
- Natural sub-module: `rr_counter` (S-bit wrapping counter with enable and synchronous reset). It is reusable by the matching mux-side arbiter.
- Top level: FSM flop, data/ctrl register, ready/valid logic. Target 120–200 lines.
- Integration bench instantiates `demux_dispatch` → `recurse_demux` and checks the demux slice for lane `ctrl` equals `data`.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid`=1 → `in_ready`=0, `lane_valid`=0, `ctrl`=0, `data`=0, `rr_ptr`=0 throughout; first accept on the cycle after release.
- Explicit routing: `rr_mode`=0, words 0x55/dest 2 then 0xAA/dest 1, all `lane_ready`=1 → `lane_valid`=4'b0100 with `data`=0x55, then 4'b0010 with 0xAA on consecutive cycles; `rr_ptr` stays 0.
- Round-robin wrap: `rr_mode`=1, 5 back-to-back words 0x01..0x05, all ready → `ctrl` sequence 0,1,2,3,0; `rr_ptr` ends at 1; one word per cycle.
- Backpressure: word 0x3C to lane 3 with `lane_ready`=4'b0111 for 4 cycles → `in_ready`=0, `data`=0x3C/`ctrl`=3 frozen; `lane_ready[3]`=1 → handoff, and the next word loads in the same cycle.
- Simultaneous handoff and accept: FULL on lane 0 with `lane_ready[0]`=1 and `in_valid`=1 → no EMPTY cycle, `lane_valid` stays asserted, new word is visible in the next cycle.
- Mid-operation reset: FULL on lane 2 with `lane_ready`=0, assert `rst` one cycle → `lane_valid`=0 next cycle, `rr_ptr`=0, and the word is never delivered.
